l2_req_responder: RTL and testbench
===================================

Name: l2_req_responder

Overview:
- Lower-level responder for L1 data-cache miss/forward traffic: accepts one L1 request at a time (read, write, or cache-line flush) and answers with a full 128-bit line plus a one-cycle done pulse.
- Holds a direct-mapped array of 16-byte lines with valid/dirty bits.
- Misses and dirty evictions go to a backing-memory port using a req/ack handshake.

Parameters:
- INDEX_BITS, 6, line index width; the array holds 2^INDEX_BITS lines.
- TAG_BITS, 54, tag width; always equals 64-4-INDEX_BITS.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  L1 request pending; held with all req_* stable until resp_done
- req_write  in  1  1=write, 0=read
- req_addr  in  64  byte address; [3:0] offset, [3+INDEX_BITS:4] index, [63:4+INDEX_BITS] tag
- req_wdata  in  64  write data, byte 0 in [7:0]
- req_size  in  3  access size, bytes = 1<<req_size; only 0..3 are legal
- req_clf  in  1  cache-line flush; overrides req_write
- resp_data  out  128  line returned to L1
- resp_done  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_done; flags an illegal request
- mem_req  out  1  memory request, held until mem_ack
- mem_write  out  1  1=writeback, 0=line fetch
- mem_addr  out  64  line-aligned address, [3:0]=0
- mem_wdata  out  128  writeback line
- mem_rdata  in  128  fetched line, valid with mem_ack
- mem_ack  in  1  one-cycle memory completion

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; all valid and dirty bits clear.
  - All outputs are 0; mem_req drops immediately, even mid-transaction. The in-flight request is abandoned.
  - The data and tag arrays are not reset.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND, WAIT_DROP.
- IDLE: when req_valid=1 at edge E, capture all req_* fields and go to LOOKUP.
- LOOKUP, one cycle:
  - Error check: req_size>3, or (addr[3:0] + bytes > 16) for a non-CLF request. On error, go to RESPOND with resp_err=1 and resp_data=0, and change no state.
  - CLF: on a hit with dirty=1, go to WRITEBACK. On a hit with dirty=0, clear valid and go to RESPOND. On a miss, go to RESPOND.
  - Read/write hit: go to RESPOND. A write merges the bytes at the offset and sets dirty.
  - Read/write miss: if the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL.
- WRITEBACK:
  - Drive mem_req=1, mem_write=1, mem_addr={victim_tag,index,4'h0}, mem_wdata=victim line.
  - On mem_ack: clear dirty. A CLF clears valid and goes to RESPOND; any other request goes to REFILL.
- REFILL:
  - Drive mem_req=1, mem_write=0, mem_addr={req tag,index,4'h0}.
  - On mem_ack: store mem_rdata, set tag, valid=1, dirty=0. A write then merges its bytes and sets dirty=1. Go to RESPOND.
- RESPOND:
  - resp_done=1 for exactly one cycle. resp_err is valid in that cycle.
  - resp_data = post-update line for read/write, 0 for CLF and errors.
  - Next state is WAIT_DROP.
- WAIT_DROP: stay while req_valid=1; go to IDLE when req_valid=0. This prevents a held request from being re-accepted.
- Latency, with E = the accepting edge:
  - A hit or error raises resp_done after edge E+2.
  - A miss adds each memory wait plus one cycle per memory phase.
- mem_req, mem_write, mem_addr, mem_wdata are registered and stable while mem_req=1. mem_req deasserts on the edge that samples mem_ack.
- mem_ack outside WRITEBACK/REFILL is ignored.
- A request whose tag equals the victim tag is a hit, never an eviction.
- resp_data holds its last value when resp_done=0. Checking it is only meaningful with resp_done=1.

Test Plan:
- Reset, then read 0x100, size 3. Expect REFILL with mem_addr=0x100. Return mem_rdata=0x00112233_44556677_8899AABB_CCDDEEFF. Expect resp_done with that resp_data, resp_err=0.
- Write 0xDEAD to 0x104, size 1. Expect a hit: resp_done 2 cycles after accept, no mem_req, and bytes [5:4] of the line = 0xDEAD. A following read of 0x100 returns the merged line.
- Read 0x100 + (1<<(INDEX_BITS+4)), same index, different tag. Expect a WRITEBACK of the dirty line to mem_addr=0x100 first, then REFILL of the new address, then resp_done.
- CLF on a dirty line. Expect a writeback, then resp_done with resp_data=0. A re-read of that address misses and issues a REFILL.
- Write size 3 at 0x10C, which crosses the line; also req_size=5. Each gives resp_err=1 with resp_done, no mem_req, and the array is unchanged.
- Assert rst_n=0 while mem_req=1 in REFILL. mem_req drops immediately. After reset release, with req_valid held high, the request is re-accepted and misses.

Source files
------------

// File: rtl/l2_req_responder.sv
// rtl/l2_req_responder.sv - direct-mapped L2 responder for L1 read/write/flush requests
module l2_req_responder #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 54
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    input  logic         req_write,
    input  logic [63:0]  req_addr,
    input  logic [63:0]  req_wdata,
    input  logic [2:0]   req_size,
    input  logic         req_clf,
    output logic [127:0] resp_data,
    output logic         resp_done,
    output logic         resp_err,
    output logic         mem_req,
    output logic         mem_write,
    output logic [63:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ack
);
    localparam int LINES = 1 << INDEX_BITS;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_REFILL    = 3'd3;
    localparam logic [2:0] S_RESPOND   = 3'd4;
    localparam logic [2:0] S_WAIT_DROP = 3'd5;

    logic [2:0]          state;
    logic                write_q;
    logic                clf_q;
    logic                err_q;
    logic [63:0]         addr_q;
    logic [63:0]         wdata_q;
    logic [2:0]          size_q;

    logic [127:0]        data_mem [LINES];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [4:0]            span;
    logic                  hit;
    logic                  err;
    logic                  lookup_write;
    logic                  refill_done;

    assign idx  = addr_q[3+INDEX_BITS:4];
    assign tag  = addr_q[63:4+INDEX_BITS];
    assign span = {1'b0, addr_q[3:0]} + (5'd1 << size_q[1:0]);
    assign hit  = valid[idx] && (tag_mem[idx] == tag);
    assign err  = (size_q > 3'd3) || (!clf_q && (span > 5'd16));

    assign lookup_write = (state == S_LOOKUP) && !err && !clf_q && write_q && hit;
    assign refill_done  = (state == S_REFILL) && mem_req && mem_ack;

    function automatic logic [127:0] merge_bytes(input logic [127:0] line,
                                                 input logic [3:0]   off,
                                                 input logic [1:0]   sz,
                                                 input logic [63:0]  wd);
        logic [127:0] r;
        int n;
        r = line;
        n = 1 << sz;
        for (int i = 0; i < 8; i++) begin
            if (i < n && (int'(off) + i) < 16)
                r[(int'(off) + i)*8 +: 8] = wd[i*8 +: 8];
        end
        return r;
    endfunction

    // Data and tag arrays carry no reset; only valid/dirty qualify their contents.
    always_ff @(posedge clk) begin
        if (lookup_write) begin
            data_mem[idx] <= merge_bytes(data_mem[idx], addr_q[3:0], size_q[1:0], wdata_q);
        end else if (refill_done) begin
            data_mem[idx] <= write_q ? merge_bytes(mem_rdata, addr_q[3:0], size_q[1:0], wdata_q)
                                     : mem_rdata;
            tag_mem[idx]  <= tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            valid     <= '0;
            dirty     <= '0;
            write_q   <= 1'b0;
            clf_q     <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            resp_data <= '0;
            resp_done <= 1'b0;
            resp_err  <= 1'b0;
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            resp_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        clf_q   <= req_clf;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    err_q <= err;
                    if (err) begin
                        state <= S_RESPOND;
                    end else if (hit && (clf_q || !write_q || !dirty[idx]) && !(clf_q && dirty[idx])) begin
                        if (clf_q) valid[idx] <= 1'b0;
                        if (write_q && !clf_q) dirty[idx] <= 1'b1;
                        state <= S_RESPOND;
                    end else if (hit && !clf_q) begin
                        dirty[idx] <= dirty[idx] | write_q;
                        state      <= S_RESPOND;
                    end else if (valid[idx] && dirty[idx]) begin
                        mem_req   <= 1'b1;
                        mem_write <= 1'b1;
                        mem_addr  <= {tag_mem[idx], idx, 4'h0};
                        mem_wdata <= data_mem[idx];
                        state     <= S_WRITEBACK;
                    end else if (clf_q) begin
                        state <= S_RESPOND;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_write <= 1'b0;
                        mem_addr  <= {tag, idx, 4'h0};
                        state     <= S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        dirty[idx] <= 1'b0;
                        if (clf_q) begin
                            valid[idx] <= 1'b0;
                            state      <= S_RESPOND;
                        end else begin
                            state <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    // After a writeback mem_req is low for one cycle before the fetch is issued.
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_write <= 1'b0;
                        mem_addr  <= {tag, idx, 4'h0};
                    end else if (mem_ack) begin
                        mem_req    <= 1'b0;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= write_q;
                        state      <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    resp_done <= 1'b1;
                    resp_err  <= err_q;
                    resp_data <= (err_q || clf_q) ? '0 : data_mem[idx];
                    state     <= S_WAIT_DROP;
                end
                S_WAIT_DROP: begin
                    if (!req_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_req_responder.sv
// tb/tb_l2_req_responder.sv - directed vector bench for l2_req_responder
module tb_l2_req_responder;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_write, req_clf;
    logic [63:0]  req_addr, req_wdata;
    logic [2:0]   req_size;
    logic [127:0] resp_data, mem_wdata, mem_rdata;
    logic         resp_done, resp_err, mem_req, mem_write, mem_ack;
    logic [63:0]  mem_addr;

    l2_req_responder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_clf(req_clf),
        .resp_data(resp_data), .resp_done(resp_done), .resp_err(resp_err),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] bmem [logic [63:0]];
    logic         tx_wr    [$];
    logic [63:0]  tx_addr  [$];
    logic [127:0] tx_wdata [$];
    int           mem_delay = 2;
    int           wait_cnt  = 0;

    function automatic logic [127:0] bm_read(input logic [63:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {~a, a};
    endfunction

    // Backing memory: acks after mem_delay cycles of mem_req, logs every transfer.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt >= mem_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = bm_read(mem_addr);
                tx_wr.push_back(mem_write);
                tx_addr.push_back(mem_addr);
                tx_wdata.push_back(mem_wdata);
                if (mem_write) bmem[mem_addr] = mem_wdata;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic wr, input logic clf, input logic [63:0] a,
                        input logic [63:0] wd, input logic [2:0] sz);
        tx_wr.delete(); tx_addr.delete(); tx_wdata.delete();
        req_write = wr; req_clf = clf; req_addr = a; req_wdata = wd; req_size = sz;
        req_valid = 1'b1;
    endtask

    task automatic wait_resp(input string name, output logic [127:0] d, output logic e,
                             output int lat);
        int n;
        n = 0; lat = -1; d = '0; e = 1'b0;
        while (n < 60 && lat < 0) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (resp_done) begin
                d = resp_data; e = resp_err; lat = n - 1;
            end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no resp_done expected resp_done within 60 cycles", name);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_pulse"}, {127'd0, resp_done}, 128'd0);
    endtask

    typedef struct {
        logic         wr;
        logic         clf;
        logic [63:0]  addr;
        logic [63:0]  wdata;
        logic [2:0]   size;
        logic         err;
        logic [127:0] data;
        int           lat;
        int           ntx;
        logic         tx_wr;
        logic [63:0]  tx_addr;
        logic [127:0] tx_wdata;
    } vec_t;

    localparam int NV = 15;
    localparam logic [127:0] L0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] L1 = 128'h00112233_44556677_8899DEAD_CCDDEEFF;
    localparam logic [127:0] P2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] L3 = 128'h0F0E0D0C_12345678_07060504_03020100;
    localparam logic [127:0] L4 = 128'hAB0E0D0C_12345678_07060504_03020100;
    localparam logic [127:0] L5 = 128'h01020304_05060708_07060504_03020100;

    initial begin
        vec_t         v [NV];
        logic [127:0] d;
        logic         e;
        int           lat;
        string        nm;
        bit           got;

        //          wr    clf   addr       wdata                  sz    err   data  lat ntx txwr  txaddr     txwdata
        v[0]  = '{1'b0, 1'b0, 64'h100, 64'h0,                  3'd3, 1'b0, L0,   -1, 1, 1'b0, 64'h100, 128'h0};
        v[1]  = '{1'b1, 1'b0, 64'h104, 64'hDEAD,               3'd1, 1'b0, L1,    2, 0, 1'b0, 64'h0,   128'h0};
        v[2]  = '{1'b0, 1'b0, 64'h100, 64'h0,                  3'd3, 1'b0, L1,    2, 0, 1'b0, 64'h0,   128'h0};
        v[3]  = '{1'b1, 1'b0, 64'h10C, 64'h1111_2222_3333_4444, 3'd3, 1'b1, 128'h0, 2, 0, 1'b0, 64'h0,  128'h0};
        v[4]  = '{1'b1, 1'b0, 64'h100, 64'h5555_6666_7777_8888, 3'd5, 1'b1, 128'h0, 2, 0, 1'b0, 64'h0,  128'h0};
        v[5]  = '{1'b0, 1'b0, 64'h100, 64'h0,                  3'd0, 1'b0, L1,    2, 0, 1'b0, 64'h0,   128'h0};
        v[6]  = '{1'b0, 1'b0, 64'h500, 64'h0,                  3'd3, 1'b0, P2,   -1, 2, 1'b1, 64'h100, L1};
        v[7]  = '{1'b1, 1'b0, 64'h508, 64'h1234_5678,          3'd2, 1'b0, L3,    2, 0, 1'b0, 64'h0,   128'h0};
        v[8]  = '{1'b0, 1'b1, 64'h500, 64'h0,                  3'd0, 1'b0, 128'h0, -1, 1, 1'b1, 64'h500, L3};
        v[9]  = '{1'b0, 1'b0, 64'h500, 64'h0,                  3'd3, 1'b0, L3,   -1, 1, 1'b0, 64'h500, 128'h0};
        v[10] = '{1'b0, 1'b1, 64'h900, 64'h0,                  3'd0, 1'b0, 128'h0, 2, 0, 1'b0, 64'h0,  128'h0};
        v[11] = '{1'b0, 1'b1, 64'h500, 64'h0,                  3'd0, 1'b0, 128'h0, 2, 0, 1'b0, 64'h0,  128'h0};
        v[12] = '{1'b0, 1'b0, 64'h500, 64'h0,                  3'd3, 1'b0, L3,   -1, 1, 1'b0, 64'h500, 128'h0};
        v[13] = '{1'b1, 1'b0, 64'h50F, 64'hAB,                 3'd0, 1'b0, L4,    2, 0, 1'b0, 64'h0,   128'h0};
        v[14] = '{1'b1, 1'b0, 64'h508, 64'h0102_0304_0506_0708, 3'd3, 1'b0, L5,    2, 0, 1'b0, 64'h0,   128'h0};

        bmem[64'h100] = L0;
        bmem[64'h500] = P2;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_clf = 1'b0;
        req_addr = '0; req_wdata = '0; req_size = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {resp_done, resp_err, mem_req, mem_write}, 128'd0);
        chk("reset_resp_data", resp_data, 128'd0);
        chk("reset_mem_addr", {64'd0, mem_addr}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            nm = $sformatf("v%0d", i);
            send(v[i].wr, v[i].clf, v[i].addr, v[i].wdata, v[i].size);
            wait_resp(nm, d, e, lat);
            chk({nm, "_err"}, {127'd0, e}, {127'd0, v[i].err});
            chk({nm, "_data"}, d, v[i].data);
            if (v[i].lat >= 0) chk({nm, "_lat"}, 128'(lat), 128'(v[i].lat));
            chk({nm, "_ntx"}, 128'(tx_addr.size()), 128'(v[i].ntx));
            if (v[i].ntx > 0 && tx_addr.size() > 0) begin
                chk({nm, "_tx0_addr"}, {64'd0, tx_addr[0]}, {64'd0, v[i].tx_addr});
                chk({nm, "_tx0_wr"}, {127'd0, tx_wr[0]}, {127'd0, v[i].tx_wr});
                if (v[i].tx_wr) chk({nm, "_tx0_wdata"}, tx_wdata[0], v[i].tx_wdata);
            end
            if (v[i].ntx > 1 && tx_addr.size() > 1)
                chk({nm, "_tx1_addr"}, {64'd0, tx_addr[1]}, {64'd0, v[i].addr & ~64'hF});
        end

        // Reset while a refill is outstanding; the held request must be re-accepted.
        mem_delay = 20;
        send(1'b0, 1'b0, 64'hA00, 64'h0, 3'd3);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (mem_req) got = 1'b1;
        end
        chk("rst_refill_started", {127'd0, got}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req_drop", {126'd0, mem_req, resp_done}, 128'd0);
        chk("rst_mem_addr", {64'd0, mem_addr}, 128'd0);
        repeat (2) @(negedge clk);
        mem_delay = 1;
        tx_wr.delete(); tx_addr.delete(); tx_wdata.delete();
        rst_n = 1'b1;
        wait_resp("rst_reaccept", d, e, lat);
        chk("rst_reaccept_data", d, {~64'hA00, 64'hA00});
        chk("rst_reaccept_err", {127'd0, e}, 128'd0);
        chk("rst_reaccept_ntx", 128'(tx_addr.size()), 128'd1);
        if (tx_addr.size() > 0)
            chk("rst_reaccept_addr", {63'd0, tx_wr[0], tx_addr[0]}, {64'd0, 64'hA00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
